// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Types and constants shared by sample_accumulator and its bench.
//   state_t             : batch controller state (IDLE, ACCUM, HOLD)
//   DEFAULT_WIDTH       : default sample/sum width
//   DEFAULT_NUM_SAMPLES : default batch length
//   count_width()       : width of a counter that must reach num_samples
// Configuration macro used by the accumulator: ACCUM_SATURATE_EN.
// -----------------------------------------------------------------------------
package accum_pkg;

    localparam int DEFAULT_WIDTH       = 8;
    localparam int DEFAULT_NUM_SAMPLES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The counter has to hold the value num_samples itself, hence the +1.
    function automatic int count_width(input int num_samples);
        return $clog2(num_samples + 1);
    endfunction

endpackage

// File: rtl/adder_nbit.sv
// -----------------------------------------------------------------------------
// adder_nbit
// Unsigned ripple-carry adder.
//   a, b     in  WIDTH  operands
//   carry_in in  1      carry into bit 0
//   sum      out WIDTH  a + b + carry_in, modulo 2^WIDTH
//   overflow out 1      unsigned carry-out of the top bit
// -----------------------------------------------------------------------------
module adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    logic carry;

    // Carry ripples from bit 0 upward; carry is a running temporary.
    always_comb begin
        carry = carry_in;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        overflow = carry;
    end

endmodule

// File: rtl/sample_accumulator.sv
// -----------------------------------------------------------------------------
// sample_accumulator
// Sums a batch of NUM_SAMPLES unsigned samples taken over a valid/ready
// stream and presents one sum plus sticky carry flag per batch.
//   clk          in  1      rising-edge clock
//   n_rst        in  1      asynchronous active-low reset
//   clear        in  1      synchronous batch abort, beats every handshake
//   in_valid     in  1      in_data is valid
//   in_data      in  WIDTH  unsigned sample
//   in_ready     out 1      sample accepted this cycle if in_valid
//   out_valid    out 1      batch result available
//   out_ready    in  1      downstream takes the result
//   out_sum      out WIDTH  batch sum (registered)
//   out_overflow out 1      any add in the batch carried out (registered)
// Configuration: define ACCUM_SATURATE_EN to clamp the sum at all-ones on
// carry-out instead of wrapping modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module sample_accumulator
    import accum_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int NUM_SAMPLES = DEFAULT_NUM_SAMPLES
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow
);

    localparam int CNT_W = count_width(NUM_SAMPLES);

    state_t           state, state_next;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_q, sticky_d;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic [WIDTH-1:0] add_next;

    // The first sample of a batch starts from zero, not from the stale result.
    assign add_a = (state == IDLE) ? '0 : sum_q;

    adder_nbit #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a        (add_a),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_carry)
    );

`ifdef ACCUM_SATURATE_EN
    // Once at all-ones any non-zero add carries again, so the clamp persists.
    assign add_next = add_carry ? '1 : add_sum;
`else
    assign add_next = add_sum;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_next = state;
        sum_d      = sum_q;
        count_d    = count_q;
        sticky_d   = sticky_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_d      = add_next;
                    count_d    = CNT_W'(1);
                    sticky_d   = 1'b0;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sum_d    = add_next;
                    sticky_d = sticky_q | add_carry;
                    count_d  = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(NUM_SAMPLES - 1)) begin
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Clear overrides whatever the handshakes above decided.
        if (clear) begin
            state_next = IDLE;
            sum_d      = '0;
            count_d    = '0;
            sticky_d   = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            sum_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            state    <= state_next;
            sum_q    <= sum_d;
            count_q  <= count_d;
            sticky_q <= sticky_d;
        end
    end

    assign out_sum      = sum_q;
    assign out_overflow = sticky_q;

endmodule

// File: tb/tb_sample_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sample_accumulator
// Self-checking bench for sample_accumulator (WIDTH=8, NUM_SAMPLES=4).
// Inputs change on the falling edge; outputs are read on the falling edge.
// Expected results come from the batch total computed with plain integer
// arithmetic: wrapped (or clamped with ACCUM_SATURATE_EN) sum, and overflow
// whenever the true total exceeds 2^WIDTH-1.
// -----------------------------------------------------------------------------
module tb_sample_accumulator;

    localparam int WIDTH = 8;
    localparam int NUM   = 4;
    localparam int MAXV  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    sample_accumulator #(
        .WIDTH       (WIDTH),
        .NUM_SAMPLES (NUM)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int model_sum(input int v[NUM]);
        int total = 0;
        for (int i = 0; i < NUM; i++) total += v[i];
`ifdef ACCUM_SATURATE_EN
        return (total > MAXV) ? MAXV : total;
`else
        return total % (MAXV + 1);
`endif
    endfunction

    function automatic bit model_ovf(input int v[NUM]);
        int total = 0;
        for (int i = 0; i < NUM; i++) total += v[i];
        return total > MAXV;
    endfunction

    // ---------------- drivers (called at a falling edge) ----------------
    task automatic send(input int d, input int gap);
        in_valid = 1'b1;
        in_data  = WIDTH'(d);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic feed(input int v[NUM], input int gap);
        for (int i = 0; i < NUM; i++) send(v[i], (i == NUM - 1) ? 0 : gap);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (out_sum !== 8'd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d expected 0", out_sum); end
        n_checks++;
        if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_out_overflow: got %b expected 0", out_overflow); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_batch();
        out_ready = 1'b1;
        send(10, 0); send(20, 0); send(30, 0);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
        send(40, 0);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        n_checks++;
        if (out_sum !== 8'd100) begin n_fail++; $display("FAIL basic_sum: got %0d expected 100", out_sum); end
        n_checks++;
        if (out_overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b expected 0", out_overflow); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL basic_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
        end
    endtask

    task automatic test_wrap_sticky();
        int v[NUM] = '{200, 100, 0, 1};
        out_ready = 1'b1;
        feed(v, 0);
        n_checks++;
        if (out_sum !== WIDTH'(model_sum(v))) begin n_fail++; $display("FAIL wrap_sum: got %0d expected %0d", out_sum, model_sum(v)); end
        n_checks++;
        if (out_overflow !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got %b expected 1", out_overflow); end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int v[NUM] = '{1, 2, 3, 4};
        out_ready = 1'b0;
        feed(v, 0);
        in_valid = 1'b1; in_data = 8'd99;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 8'd10) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid=%b ready=%b sum=%0d expected valid=1 ready=0 sum=10",
                         c, out_valid, in_ready, out_sum);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        // sum still 10: the sample offered during the handshake was not taken
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 8'd10) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b ready=%b sum=%0d expected valid=0 ready=1 sum=10",
                     out_valid, in_ready, out_sum);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear();
        int ones[NUM]  = '{1, 1, 1, 1};
        int sevens[NUM] = '{7, 7, 7, 7};
        out_ready = 1'b1;
        send(50, 0); send(60, 0);
        clear = 1'b1; in_valid = 1'b1; in_data = 8'd70;
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_sum !== 8'd0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_state: got sum=%0d ready=%b valid=%b expected sum=0 ready=1 valid=0",
                     out_sum, in_ready, out_valid);
        end
        feed(ones, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd4) begin
            n_fail++; $display("FAIL clear_next_batch: got valid=%b sum=%0d expected valid=1 sum=4", out_valid, out_sum);
        end
        @(negedge clk);
        // clear in HOLD drops the pending result
        out_ready = 1'b0;
        feed(sevens, 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0) begin
            n_fail++; $display("FAIL clear_hold: got valid=%b sum=%0d expected valid=0 sum=0", out_valid, out_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int v[NUM] = '{9, 9, 9, 250};
        out_ready = 1'b0;
        feed(v, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_overflow !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre_hold: got valid=%b ovf=%b expected valid=1 ovf=1", out_valid, out_overflow);
        end
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_sum !== 8'd0 || out_overflow !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_immediate: got valid=%b sum=%0d ovf=%b ready=%b expected 0 0 0 1",
                     out_valid, out_sum, out_overflow, in_ready);
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gapped();
        out_ready = 1'b1;
        send(5, 3); send(5, 3); send(5, 3);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid: got %b expected 0", out_valid); end
        send(5, 0);
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== 8'd20) begin
            n_fail++; $display("FAIL gap_result: got valid=%b sum=%0d expected valid=1 sum=20", out_valid, out_sum);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int v[NUM];
        int gap;
        int hold;
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < NUM; i++) v[i] = (b % 2 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 60));
            gap  = int'($urandom_range(0, 2));
            hold = int'($urandom_range(0, 3));
            out_ready = 1'b0;
            feed(v, gap);
            for (int c = 0; c <= hold; c++) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_sum !== WIDTH'(model_sum(v)) || out_overflow !== model_ovf(v)) begin
                    n_fail++;
                    $display("FAIL rand_batch[%0d]: got valid=%b sum=%0d ovf=%b expected valid=1 sum=%0d ovf=%b",
                             b, out_valid, out_sum, out_overflow, model_sum(v), model_ovf(v));
                end
                if (c == hold) out_ready = 1'b1;
                @(negedge clk);
            end
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_release[%0d]: got %b expected 0", b, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_batch();
        test_wrap_sticky();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_gapped();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
